// File: rtl/led_pkg.sv
// Shared encodings for the LED breathe/PWM driver: output modes and breathe FSM phases.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_SOLID   = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      RAMP_UP   = 2'd0,
      HOLD_HIGH = 2'd1,
      RAMP_DOWN = 2'd2,
      HOLD_LOW  = 2'd3
   } phase_e;

endpackage

// File: rtl/toggle_to_pulse.sv
// Turns every edge of a slow toggling level into a single-cycle pulse.
module toggle_to_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse,
   output logic level_d
);

   logic level_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign pulse   = level ^ level_q;
   assign level_d = level_q;

endmodule

// File: rtl/led_breathe_pwm.sv
// LED driver: off/solid/blink modes plus a PWM "breathe" ramp paced by an external step toggle.
module led_breathe_pwm
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned HOLD_TICKS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                step_in,
   input  logic [1:0]          mode,
   output logic                led_out,
   output logic [PWM_BITS-1:0] duty,
   output logic [1:0]          phase
);

   localparam int unsigned HoldW = $clog2(HOLD_TICKS) + 1;
   localparam logic [PWM_BITS-1:0] DutyMax  = '1;
   localparam logic [PWM_BITS-1:0] DutyOne  = PWM_BITS'(1);
   localparam logic [HoldW-1:0]    HoldLast = HoldW'(HOLD_TICKS - 1);

   mode_e               mode_s;
   logic                step_pulse;
   logic                step_d;
   logic                is_breathe;
   logic                breathe_q;
   logic                advance;

   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                led_out_q, led_out_d;
   phase_e              state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [HoldW-1:0]    hold_q, hold_d;

   assign mode_s     = mode_e'(mode);
   assign is_breathe = (mode_s == MODE_BREATHE);
   // breathe_q gates stepping so a pulse landing on the entry cycle is dropped
   assign advance    = step_pulse & enable & is_breathe & breathe_q;

   toggle_to_pulse u_step (
      .clk     (clk),
      .rst     (rst),
      .level   (step_in),
      .pulse   (step_pulse),
      .level_d (step_d)
   );

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      if (!is_breathe) begin
         state_d = RAMP_UP;
         duty_d  = '0;
         hold_d  = '0;
      end else if (advance) begin
         unique case (state_q)
            RAMP_UP: begin
               if (duty_q >= DutyMax - DutyOne) begin
                  duty_d  = DutyMax;
                  state_d = HOLD_HIGH;
                  hold_d  = '0;
               end else begin
                  duty_d = duty_q + DutyOne;
               end
            end
            HOLD_HIGH: begin
               if (hold_q >= HoldLast) begin
                  state_d = RAMP_DOWN;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            RAMP_DOWN: begin
               if (duty_q <= DutyOne) begin
                  duty_d  = '0;
                  state_d = HOLD_LOW;
                  hold_d  = '0;
               end else begin
                  duty_d = duty_q - DutyOne;
               end
            end
            HOLD_LOW: begin
               if (hold_q >= HoldLast) begin
                  state_d = RAMP_UP;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            default: begin
               state_d = RAMP_UP;
               duty_d  = '0;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      led_out_d = 1'b0;
      unique case (mode_s)
         MODE_OFF:     led_out_d = 1'b0;
         MODE_SOLID:   led_out_d = 1'b1;
         MODE_BLINK:   led_out_d = step_d;
         MODE_BREATHE: led_out_d = (pwm_cnt_q < duty_q);
         default:      led_out_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         led_out_q <= 1'b0;
         state_q   <= RAMP_UP;
         duty_q    <= '0;
         hold_q    <= '0;
         breathe_q <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + DutyOne;
         led_out_q <= led_out_d;
         state_q   <= state_d;
         duty_q    <= duty_d;
         hold_q    <= hold_d;
         breathe_q <= is_breathe;
      end
   end

   assign led_out = led_out_q;
   assign duty    = duty_q;
   assign phase   = state_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with a queue scoreboard of expected values.
module tb_led_breathe_pwm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       step_in = 1'b0;
   logic [1:0] mode = 2'd3;
   logic       led_out;
   logic [7:0] duty;
   logic [1:0] phase;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   led_breathe_pwm #(
      .PWM_BITS   (8),
      .HOLD_TICKS (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .step_in (step_in),
      .mode    (mode),
      .led_out (led_out),
      .duty    (duty),
      .phase   (phase)
   );

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %0d required nothing", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", t, obs, e);
      end
   endtask

   task automatic chk_dp(input string tag, input int exp_duty, input int exp_phase);
      expect_val({tag, "_duty"}, exp_duty);
      check({24'd0, duty});
      expect_val({tag, "_phase"}, exp_phase);
      check({30'd0, phase});
   endtask

   // Each toggle lands on a falling edge; one extra cycle lets the last one register.
   task automatic toggles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         step_in = ~step_in;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_high(input string tag, input int n, input int exp_cnt);
      int c;
      c = 0;
      expect_val(tag, exp_cnt);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (led_out === 1'b1) c++;
      end
      check(c);
   endtask

   initial begin
      logic old_lvl;

      // Reset state
      idle(3);
      chk_dp("reset", 0, 0);
      expect_val("reset_led", 0);
      check({31'd0, led_out});
      rst = 1'b0;
      idle(4);
      chk_dp("post_reset_no_step", 0, 0);
      count_high("pwm_duty0", 256, 0);

      // Ramp up to full and hold boundary
      toggles(255);
      chk_dp("ramp_up_full", 255, 1);
      count_high("pwm_duty255", 256, 255);
      toggles(15);
      chk_dp("hold_high_15", 255, 1);
      toggles(1);
      chk_dp("hold_high_exit", 255, 2);

      // Ramp down and hold low, completing the cycle
      toggles(1);
      chk_dp("ramp_down_first", 254, 2);
      toggles(254);
      chk_dp("ramp_down_zero", 0, 3);
      toggles(16);
      chk_dp("full_cycle", 0, 0);

      // Freeze with enable low; PWM counter keeps running
      toggles(50);
      chk_dp("ramp_50", 50, 0);
      enable = 1'b0;
      toggles(10);
      chk_dp("enable_low", 50, 0);
      count_high("pwm_duty50_frozen", 256, 50);
      enable = 1'b1;
      toggles(14);
      chk_dp("ramp_64", 64, 0);
      count_high("pwm_duty64", 256, 64);

      // Leave BREATHE at duty 100, then blink follows step_d
      toggles(36);
      chk_dp("ramp_100", 100, 0);
      mode = 2'd2;
      idle(1);
      chk_dp("blink_clear", 0, 0);
      expect_val("blink_steady", {31'd0, step_in});
      check({31'd0, led_out});
      old_lvl = step_in;
      toggles(1);
      expect_val("blink_lag", {31'd0, old_lvl});
      check({31'd0, led_out});
      idle(1);
      expect_val("blink_follow", {31'd0, ~old_lvl});
      check({31'd0, led_out});

      // Step coinciding with entry into BREATHE is ignored
      @(negedge clk);
      mode = 2'd3;
      step_in = ~step_in;
      @(negedge clk);
      chk_dp("entry_step_ignored", 0, 0);
      toggles(1);
      chk_dp("first_step_after_entry", 1, 0);

      // Solid and off
      mode = 2'd1;
      idle(1);
      expect_val("solid_led", 1);
      check({31'd0, led_out});
      chk_dp("solid_clear", 0, 0);
      mode = 2'd0;
      idle(1);
      expect_val("off_led", 0);
      check({31'd0, led_out});

      // Asynchronous reset in the middle of HOLD_HIGH
      mode = 2'd3;
      idle(1);
      toggles(255);
      toggles(5);
      chk_dp("pre_async_rst", 255, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_dp("async_rst", 0, 0);
      expect_val("async_rst_led", 0);
      check({31'd0, led_out});
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
